// File: rtl/datapath_bus.sv
// datapath_bus: 16-bit accumulator datapath around a single shared bus.
// All registers load from the bus on the rising clock edge; the control unit
// (external) drives the strobes from its falling-edge state machine.
//
// Ports:
//   clk            rising-edge datapath clock
//   rst_n          asynchronous active-low reset
//   write_enable   [16:0] register load strobes (bit map below)
//   read_enable    [4:0]  bus source select code
//   increment      [5:0]  increment strobes: PC, AC, STXY, STXZ, R, R3
//   alu            [2:0]  ALU op: 1 ADD, 2 MUL, 3 SUB, 4 SFTR, 5 SFTL, else no-op
//   ins_mem_data   [15:0] instruction memory read data (address pc)
//   data_mem_rdata [15:0] data memory read data (address ar)
//   instruction    [15:0] IR contents
//   Z                     zero flag, updated only by ALU_AC loads
//   pc, ar         [15:0] memory addresses
//   data_mem_wdata [15:0] equal to bus
//   data_mem_we           equal to write_enable[0]
//   bus            [15:0] current bus value
//   ac             [15:0] accumulator
//
// write_enable: 0 DATA_MEM, 1 ALU_AC, 2 IR_PC, 3 IR, 4 AR, 5 X, 6 Y, 7 ZR,
//               8 STXY, 9 STYZ, 10 STXZ, 11 R, 12 R1, 13 R2, 14 R3, 15 DR, 16 AC
module datapath_bus (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [16:0] write_enable,
    input  logic [4:0]  read_enable,
    input  logic [5:0]  increment,
    input  logic [2:0]  alu,
    input  logic [15:0] ins_mem_data,
    input  logic [15:0] data_mem_rdata,
    output logic [15:0] instruction,
    output logic        Z,
    output logic [15:0] pc,
    output logic [15:0] ar,
    output logic [15:0] data_mem_wdata,
    output logic        data_mem_we,
    output logic [15:0] bus,
    output logic [15:0] ac
);

    logic [15:0] pc_q, ir_q, ar_q, ac_q, x_q, y_q, zr_q;
    logic [15:0] stxy_q, styz_q, stxz_q, r_q, r1_q, r2_q, r3_q, dr_q;
    logic [15:0] alu_res_q, alu_res_d;
    logic        z_q;
    logic        alu_valid;

    // Bus source mux; unused codes read as zero.
    always_comb begin
        bus = 16'h0000;
        case (read_enable)
            5'd1:    bus = ins_mem_data;
            5'd2:    bus = data_mem_rdata;
            5'd3:    bus = pc_q;
            5'd4:    bus = ir_q;
            5'd5:    bus = ar_q;
            5'd6:    bus = ac_q;
            5'd7:    bus = x_q;
            5'd8:    bus = y_q;
            5'd9:    bus = zr_q;
            5'd10:   bus = stxy_q;
            5'd11:   bus = styz_q;
            5'd12:   bus = stxz_q;
            5'd13:   bus = r_q;
            5'd14:   bus = r1_q;
            5'd15:   bus = r2_q;
            5'd16:   bus = r3_q;
            5'd17:   bus = dr_q;
            default: bus = 16'h0000;
        endcase
    end

    // Next ALU result from the pre-edge ac and bus; truncated to 16 bits.
    always_comb begin
        alu_res_d = alu_res_q;
        alu_valid = 1'b1;
        case (alu)
            3'd1:    alu_res_d = ac_q + bus;
            3'd2:    alu_res_d = ac_q * bus;
            3'd3:    alu_res_d = ac_q - bus;
            3'd4:    alu_res_d = ac_q >> 1;
            3'd5:    alu_res_d = ac_q << 1;
            default: alu_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= 16'h0000;
            ir_q      <= 16'h0000;
            ar_q      <= 16'h0000;
            ac_q      <= 16'h0000;
            x_q       <= 16'h0000;
            y_q       <= 16'h0000;
            zr_q      <= 16'h0000;
            stxy_q    <= 16'h0000;
            styz_q    <= 16'h0000;
            stxz_q    <= 16'h0000;
            r_q       <= 16'h0000;
            r1_q      <= 16'h0000;
            r2_q      <= 16'h0000;
            r3_q      <= 16'h0000;
            dr_q      <= 16'h0000;
            alu_res_q <= 16'h0000;
            z_q       <= 1'b0;
        end else begin
            if (write_enable[3])  ir_q  <= bus;
            if (write_enable[4])  ar_q  <= bus;
            if (write_enable[5])  x_q   <= bus;
            if (write_enable[6])  y_q   <= bus;
            if (write_enable[7])  zr_q  <= bus;
            if (write_enable[9])  styz_q <= bus;
            if (write_enable[12]) r1_q  <= bus;
            if (write_enable[13]) r2_q  <= bus;
            if (write_enable[15]) dr_q  <= bus;

            // Loads win over increments on the same register.
            if (write_enable[2])      pc_q <= {8'h00, ir_q[7:0]};
            else if (increment[0])    pc_q <= pc_q + 16'd1;

            if (write_enable[8])      stxy_q <= bus;
            else if (increment[2])    stxy_q <= stxy_q + 16'd1;

            if (write_enable[10])     stxz_q <= bus;
            else if (increment[3])    stxz_q <= stxz_q + 16'd1;

            if (write_enable[11])     r_q <= bus;
            else if (increment[4])    r_q <= r_q + 16'd1;

            if (write_enable[14])     r3_q <= bus;
            else if (increment[5])    r3_q <= r3_q + 16'd1;

            // Z tracks only ALU results reaching ac.
            if (write_enable[16]) begin
                ac_q <= bus;
            end else if (write_enable[1]) begin
                ac_q <= alu_res_q;
                z_q  <= (alu_res_q == 16'h0000);
            end else if (increment[1]) begin
                ac_q <= ac_q + 16'd1;
            end

            if (alu_valid) alu_res_q <= alu_res_d;
        end
    end

    assign instruction    = ir_q;
    assign Z              = z_q;
    assign pc             = pc_q;
    assign ar             = ar_q;
    assign ac             = ac_q;
    assign data_mem_wdata = bus;
    assign data_mem_we    = write_enable[0];

endmodule

// File: tb/tb_datapath_bus.sv
module tb_datapath_bus;

    logic        clk;
    logic        rst_n;
    logic [16:0] write_enable;
    logic [4:0]  read_enable;
    logic [5:0]  increment;
    logic [2:0]  alu;
    logic [15:0] ins_mem_data;
    logic [15:0] data_mem_rdata;
    logic [15:0] instruction;
    logic        Z;
    logic [15:0] pc;
    logic [15:0] ar;
    logic [15:0] data_mem_wdata;
    logic        data_mem_we;
    logic [15:0] bus;
    logic [15:0] ac;

    int checks = 0;
    int failures = 0;

    datapath_bus dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .write_enable   (write_enable),
        .read_enable    (read_enable),
        .increment      (increment),
        .alu            (alu),
        .ins_mem_data   (ins_mem_data),
        .data_mem_rdata (data_mem_rdata),
        .instruction    (instruction),
        .Z              (Z),
        .pc             (pc),
        .ar             (ar),
        .data_mem_wdata (data_mem_wdata),
        .data_mem_we    (data_mem_we),
        .bus            (bus),
        .ac             (ac)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Apply one set of strobes across one rising edge, then idle the strobes.
    task automatic cyc(input logic [16:0] we, input logic [4:0] re,
                       input logic [5:0] inc, input logic [2:0] op);
        write_enable = we;
        read_enable  = re;
        increment    = inc;
        alu          = op;
        @(posedge clk);
        #1;
        write_enable = '0;
        read_enable  = '0;
        increment    = '0;
        alu          = '0;
    endtask

    function automatic logic [16:0] web(input int b);
        logic [16:0] v;
        v = '0;
        v[b] = 1'b1;
        return v;
    endfunction

    initial begin
        rst_n = 1'b0;
        write_enable = '0;
        read_enable = '0;
        increment = '0;
        alu = '0;
        ins_mem_data = '0;
        data_mem_rdata = '0;
        #3;
        check_eq("rst_ac", ac, 16'h0000);
        check_eq("rst_pc", pc, 16'h0000);
        check_eq("rst_ar", ar, 16'h0000);
        check_eq("rst_ir", instruction, 16'h0000);
        check_eq("rst_z", {15'd0, Z}, 16'h0000);
        // Bus and memory strobes stay live during reset.
        ins_mem_data = 16'h1357;
        read_enable = 5'd1;
        write_enable = web(0);
        #1;
        check_eq("rst_bus", bus, 16'h1357);
        check_eq("rst_wdata", data_mem_wdata, 16'h1357);
        check_eq("rst_we", {15'd0, data_mem_we}, 16'h0001);
        read_enable = 5'd0;
        write_enable = '0;
        #1;
        check_eq("bus_none", bus, 16'h0000);
        #17 rst_n = 1'b1;
        @(negedge clk);

        // Fetch
        ins_mem_data = 16'h0512;
        cyc(web(3), 5'd1, 6'd0, 3'd0);
        cyc('0, 5'd0, 6'b000001, 3'd0);
        check_eq("fetch_ir", instruction, 16'h0512);
        check_eq("fetch_pc", pc, 16'h0001);
        cyc(web(2), 5'd0, 6'b000001, 3'd0);
        check_eq("irpc_pc", pc, 16'h0012);

        // ADD: ac=3, R=4
        ins_mem_data = 16'h0003;
        cyc(web(16), 5'd1, 6'd0, 3'd0);
        ins_mem_data = 16'h0004;
        cyc(web(11), 5'd1, 6'd0, 3'd0);
        read_enable = 5'd13;
        #1;
        check_eq("bus_r", bus, 16'h0004);
        cyc('0, 5'd13, 6'd0, 3'd1);
        check_eq("add_pre_ac", ac, 16'h0003);
        cyc(web(1), 5'd0, 6'd0, 3'd0);
        check_eq("add_ac", ac, 16'h0007);
        check_eq("add_z", {15'd0, Z}, 16'h0000);

        // SUB to zero; ac and R loaded together
        ins_mem_data = 16'h1234;
        cyc(web(16) | web(11), 5'd1, 6'd0, 3'd0);
        check_eq("multi_ac", ac, 16'h1234);
        cyc('0, 5'd13, 6'd0, 3'd3);
        cyc(web(1), 5'd0, 6'd0, 3'd0);
        check_eq("sub_ac", ac, 16'h0000);
        check_eq("sub_z", {15'd0, Z}, 16'h0001);
        cyc('0, 5'd0, 6'b000010, 3'd0);
        check_eq("inc_ac", ac, 16'h0001);
        check_eq("inc_z", {15'd0, Z}, 16'h0001);

        // PC wrap: pc=0x00FF then 0xFF00 increments to 0xFFFF
        ins_mem_data = 16'h00FF;
        cyc(web(3), 5'd1, 6'd0, 3'd0);
        cyc(web(2), 5'd0, 6'd0, 3'd0);
        check_eq("pc_ff", pc, 16'h00FF);
        increment = 6'b000001;
        repeat (16'hFF00) begin
            @(posedge clk);
            #1;
        end
        check_eq("pc_max", pc, 16'hFFFF);
        @(posedge clk);
        #1;
        increment = '0;
        check_eq("pc_wrap", pc, 16'h0000);

        // Load beats increment on R
        ins_mem_data = 16'h00AA;
        cyc(web(11), 5'd1, 6'b010000, 3'd0);
        read_enable = 5'd13;
        #1;
        check_eq("r_prio", bus, 16'h00AA);
        cyc('0, 5'd0, 6'b010000, 3'd0);
        read_enable = 5'd13;
        #1;
        check_eq("r_inc", bus, 16'h00AB);

        // MUL
        ins_mem_data = 16'h0100;
        cyc(web(16), 5'd1, 6'd0, 3'd0);
        ins_mem_data = 16'h0101;
        cyc(web(12), 5'd1, 6'd0, 3'd0);
        cyc('0, 5'd14, 6'd0, 3'd2);
        cyc(web(1), 5'd0, 6'd0, 3'd0);
        check_eq("mul_ac", ac, 16'h0100);

        // SFTL / SFTR
        ins_mem_data = 16'h8001;
        cyc(web(16), 5'd1, 6'd0, 3'd0);
        cyc('0, 5'd0, 6'd0, 3'd5);
        cyc(web(1), 5'd0, 6'd0, 3'd0);
        check_eq("sftl_ac", ac, 16'h0002);
        cyc(web(16), 5'd1, 6'd0, 3'd0);
        cyc('0, 5'd0, 6'd0, 3'd4);
        cyc(web(1), 5'd0, 6'd0, 3'd0);
        check_eq("sftr_ac", ac, 16'h4000);
        check_eq("sftr_z", {15'd0, Z}, 16'h0000);

        // Data memory path
        data_mem_rdata = 16'hBEEF;
        cyc(web(4), 5'd2, 6'd0, 3'd0);
        check_eq("ar_load", ar, 16'hBEEF);

        // Reset mid-ALU: set Z, pc nonzero, then capture alu_res=8
        ins_mem_data = 16'h0005;
        cyc(web(16) | web(11), 5'd1, 6'b000001, 3'd0);
        cyc('0, 5'd13, 6'd0, 3'd3);
        cyc(web(1), 5'd0, 6'd0, 3'd0);
        check_eq("pre_z", {15'd0, Z}, 16'h0001);
        ins_mem_data = 16'h0003;
        cyc(web(11) | web(16), 5'd1, 6'd0, 3'd0);
        ins_mem_data = 16'h0005;
        cyc(web(16), 5'd1, 6'd0, 3'd0);
        cyc('0, 5'd13, 6'd0, 3'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_ac", ac, 16'h0000);
        check_eq("mid_pc", pc, 16'h0000);
        check_eq("mid_ar", ar, 16'h0000);
        check_eq("mid_z", {15'd0, Z}, 16'h0000);
        read_enable = 5'd13;
        #1;
        check_eq("mid_r", bus, 16'h0000);
        read_enable = 5'd0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(web(1), 5'd0, 6'd0, 3'd0);
        check_eq("post_ac", ac, 16'h0000);
        check_eq("post_z", {15'd0, Z}, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
